mc_payoff_engine: RTL and testbench

//   Parametrised successor to the Monte Carlo option-pricing core. It consumes a stream of

---
 rtl/mc_payoff_engine_if.sv | 31 +++
 rtl/mc_payoff_engine.sv | 114 +++++++++++
 tb/tb_mc_payoff_engine.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mc_payoff_engine_if.sv
// Handshake and result bus between the path generator/host and the payoff engine.
interface mc_payoff_engine_if #(
  parameter int unsigned W          = 12,
  parameter int unsigned LOG2_PATHS = 8,
  parameter int unsigned DF_W       = 12
);

  logic            start;
  logic            mode;
  logic [W-1:0]    K;
  logic [DF_W-1:0] df;
  logic            path_valid;
  logic [W-1:0]    path;
  logic            path_ready;
  logic            busy;
  logic            valid;
  logic [W-1:0]    price;

  // Host/producer side.
  modport master (
    output start, mode, K, df, path_valid, path,
    input  path_ready, busy, valid, price
  );

  // Engine side.
  modport slave (
    input  start, mode, K, df, path_valid, path,
    output path_ready, busy, valid, price
  );

endinterface

// File: rtl/mc_payoff_engine.sv
// Monte Carlo payoff engine: averages call/put payoffs over 2**LOG2_PATHS
// samples and applies a Q0.DF_W discount factor.
module mc_payoff_engine #(
  parameter int unsigned W          = 12,
  parameter int unsigned LOG2_PATHS = 8,
  parameter int unsigned DF_W       = 12
) (
  input logic               clk,
  input logic               rst_n,
  mc_payoff_engine_if.slave bus
);

  localparam int unsigned ACC_W     = W + LOG2_PATHS;
  localparam int unsigned CNT_W     = (LOG2_PATHS > 0) ? LOG2_PATHS : 1;
  localparam int unsigned NUM_PATHS = 1 << LOG2_PATHS;
  localparam int unsigned PROD_W    = W + DF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_AVG  = 2'd2,
    S_DISC = 2'd3
  } state_t;

  state_t          state_q;
  logic            mode_q;
  logic [W-1:0]    k_q;
  logic [DF_W-1:0] df_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]    avg_q;
  logic            path_ready_q;
  logic            busy_q;
  logic            valid_q;
  logic [W-1:0]    price_q;

  logic [W-1:0]      payoff_c;
  logic              accept_c;
  logic              last_c;
  logic [PROD_W-1:0] prod_c;

  // Per-sample payoff, accept qualifier and discounted product.
  always_comb begin
    payoff_c = '0;
    if (!mode_q) begin
      if (bus.path > k_q) payoff_c = bus.path - k_q;
    end else begin
      if (k_q > bus.path) payoff_c = k_q - bus.path;
    end
    accept_c = bus.path_valid & path_ready_q;
    last_c   = (cnt_q == CNT_W'(NUM_PATHS - 1));
    prod_c   = PROD_W'(avg_q) * PROD_W'(df_q);
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      k_q          <= '0;
      df_q         <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      avg_q        <= '0;
      path_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      price_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            mode_q       <= bus.mode;
            k_q          <= bus.K;
            df_q         <= bus.df;
            acc_q        <= '0;
            cnt_q        <= '0;
            path_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept_c) begin
            acc_q <= acc_q + ACC_W'(payoff_c);
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_c) begin
              path_ready_q <= 1'b0;
              state_q      <= S_AVG;
            end
          end
        end
        S_AVG: begin
          avg_q   <= W'(acc_q >> LOG2_PATHS);
          state_q <= S_DISC;
        end
        S_DISC: begin
          price_q <= W'(prod_c >> DF_W);
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.path_ready = path_ready_q;
  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.price      = price_q;

endmodule

// File: tb/tb_mc_payoff_engine.sv
// Directed and randomized bench for mc_payoff_engine (W=12, LOG2_PATHS=2, DF_W=12).
module tb_mc_payoff_engine;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [11:0] pa [4];

  mc_payoff_engine_if #(.W(12), .LOG2_PATHS(2), .DF_W(12)) bus ();

  mc_payoff_engine #(.W(12), .LOG2_PATHS(2), .DF_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference price from the payoff rules in plain integer arithmetic.
  function automatic logic [11:0] ref_price(input logic m, input logic [11:0] k, input logic [11:0] d);
    int sum;
    int avg;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (!m && int'(pa[i]) > int'(k)) sum += int'(pa[i]) - int'(k);
      if (m && int'(k) > int'(pa[i]))  sum += int'(k) - int'(pa[i]);
    end
    avg = sum / 4;
    return 12'((avg * int'(d)) / 4096);
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One estimate on pa[]; starts now, returns in the valid cycle.
  task automatic run_est(input logic m, input logic [11:0] k, input logic [11:0] d,
                         input int gap, input bit poke, input string tag);
    logic [11:0] exp;
    exp = ref_price(m, k, d);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.K     = k;
    bus.df    = d;
    step();
    bus.start = poke;
    bus.mode  = 1'($urandom);
    bus.K     = 12'($urandom);
    bus.df    = 12'($urandom);
    chk(tag, "busy_start", 32'(bus.busy), 32'd1);
    chk(tag, "ready_start", 32'(bus.path_ready), 32'd1);
    chk(tag, "valid_start", 32'(bus.valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.path       = pa[i];
      bus.path_valid = 1'b1;
      step();
      bus.path_valid = 1'b0;
      bus.path       = 12'($urandom);
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          chk(tag, "ready_gap", 32'(bus.path_ready), 32'd1);
          step();
        end
      end
    end
    if (poke) begin
      bus.path_valid = 1'b1;
      bus.path       = 12'hFFF;
    end
    chk(tag, "ready_avg", 32'(bus.path_ready), 32'd0);
    chk(tag, "busy_avg", 32'(bus.busy), 32'd1);
    chk(tag, "valid_avg", 32'(bus.valid), 32'd0);
    step();
    chk(tag, "valid_disc", 32'(bus.valid), 32'd0);
    chk(tag, "busy_disc", 32'(bus.busy), 32'd1);
    step();
    bus.start      = 1'b0;
    bus.path_valid = 1'b0;
    chk(tag, "valid", 32'(bus.valid), 32'd1);
    chk(tag, "price", 32'(bus.price), 32'(exp));
    chk(tag, "busy_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic load_call_paths();
    pa[0] = 12'h400; pa[1] = 12'h200; pa[2] = 12'h300; pa[3] = 12'h500;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.K = '0; bus.df = '0;
    bus.path_valid = 1'b0; bus.path = '0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      bus.start = 1'($urandom); bus.mode = 1'($urandom); bus.K = 12'($urandom);
      bus.df = 12'($urandom); bus.path_valid = 1'($urandom); bus.path = 12'($urandom);
      #7;
      chk("reset", "ready", 32'(bus.path_ready), 32'd0);
      chk("reset", "busy", 32'(bus.busy), 32'd0);
      chk("reset", "valid", 32'(bus.valid), 32'd0);
      chk("reset", "price", 32'(bus.price), 32'd0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.path_valid = 1'($urandom); bus.path = 12'($urandom);
      step();
      chk("idle", "valid", 32'(bus.valid), 32'd0);
      chk("idle", "busy", 32'(bus.busy), 32'd0);
      chk("idle", "ready", 32'(bus.path_ready), 32'd0);
    end
    bus.path_valid = 1'b0;

    // Call, back-to-back samples.
    load_call_paths();
    run_est(1'b0, 12'h300, 12'h800, 0, 1'b0, "call");
    chk("call", "price_const", 32'(bus.price), 32'h060);
    step();
    chk("call", "valid_width", 32'(bus.valid), 32'd0);
    chk("call", "price_hold", 32'(bus.price), 32'h060);

    // Put with 3-cycle gaps.
    run_est(1'b1, 12'h300, 12'h800, 3, 1'b0, "put");
    chk("put", "price_const", 32'(bus.price), 32'h020);
    step();

    // Maximum values.
    for (int i = 0; i < 4; i++) pa[i] = 12'hFFF;
    run_est(1'b0, 12'h000, 12'hFFF, 0, 1'b0, "max");
    chk("max", "price_const", 32'(bus.price), 32'hFFE);
    step();

    // Start ignored while busy, then accepted in the valid cycle.
    load_call_paths();
    run_est(1'b0, 12'h300, 12'h800, 1, 1'b1, "poke");
    chk("poke", "price_const", 32'(bus.price), 32'h060);
    run_est(1'b1, 12'h300, 12'h800, 0, 1'b0, "chain");
    chk("chain", "price_const", 32'(bus.price), 32'h020);
    step();

    // Reset in the middle of RUN.
    bus.start = 1'b1; bus.mode = 1'b0; bus.K = 12'h000; bus.df = 12'hFFF;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.path = 12'hFFF; bus.path_valid = 1'b1;
      step();
    end
    bus.path_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst", "busy", 32'(bus.busy), 32'd0);
    chk("midrst", "ready", 32'(bus.path_ready), 32'd0);
    chk("midrst", "price", 32'(bus.price), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    load_call_paths();
    run_est(1'b0, 12'h300, 12'h800, 0, 1'b0, "after_rst");
    chk("after_rst", "price_const", 32'(bus.price), 32'h060);

    // Randomized estimates, chained back-to-back.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++) pa[i] = 12'($urandom);
      run_est(1'($urandom), 12'($urandom), 12'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom), "rand");
    end
    step();
    chk("end", "valid", 32'(bus.valid), 32'd0);
    chk("end", "busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
